// File: rtl/chimera_cfg_switch.sv
// chimera_cfg_switch: runtime selector for one of NumCfgs configuration presets.
// A switch request quiesces the downstream fabric through an isolate handshake,
// applies the new preset, holds isolation for a settle window, then releases.
module chimera_cfg_switch #(
    parameter  int unsigned NumCfgs       = 4,
    parameter  int unsigned CfgWidth      = 32,
    parameter  int unsigned DefaultIdx    = 0,
    parameter  int unsigned SettleCycles  = 8,
    parameter  int unsigned TimeoutCycles = 1024,
    localparam int unsigned IdxWidth      = (NumCfgs > 1) ? $clog2(NumCfgs) : 1
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NumCfgs*CfgWidth-1:0] presets_i,
    input  logic                        req_valid_i,
    output logic                        req_ready_o,
    input  logic [IdxWidth-1:0]         req_idx_i,
    input  logic                        busy_i,
    output logic                        isolate_req_o,
    input  logic                        isolate_ack_i,
    output logic [CfgWidth-1:0]         cfg_o,
    output logic [IdxWidth-1:0]         cfg_idx_o,
    output logic                        cfg_valid_o,
    output logic                        done_o,
    output logic                        err_o
);

    // One counter serves the INIT/SETTLE windows and the DRAIN timeout.
    localparam int unsigned CntMax   = (SettleCycles > TimeoutCycles) ? SettleCycles : TimeoutCycles;
    localparam int unsigned CntWidth = $clog2(CntMax + 1);

    localparam logic [CntWidth-1:0] SETTLE_LAST  = CntWidth'((SettleCycles == 0) ? 0 : SettleCycles - 1);
    localparam logic [CntWidth-1:0] TIMEOUT_LAST = CntWidth'(TimeoutCycles - 1);
    localparam logic [CntWidth-1:0] CNT_ONE      = CntWidth'(1);
    localparam logic [IdxWidth:0]   NUM_CFGS     = (IdxWidth + 1)'(NumCfgs);
    localparam logic [IdxWidth-1:0] DEFAULT_IDX  = IdxWidth'(DefaultIdx);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_DRAIN,
        ST_APPLY,
        ST_SETTLE,
        ST_RELEASE
    } state_t;

    state_t               state;
    logic [CntWidth-1:0]  cnt;
    logic [IdxWidth-1:0]  active_idx;
    logic [IdxWidth-1:0]  target_idx;
    logic                 abort;
    logic                 idx_oob;

    assign idx_oob   = ({1'b0, req_idx_i} >= NUM_CFGS);
    assign cfg_idx_o = active_idx;

    // Select the active preset word from the static table.
    always_comb begin
        cfg_o = '0;
        for (int unsigned k = 0; k < NumCfgs; k++) begin
            if (active_idx == IdxWidth'(k)) begin
                cfg_o = presets_i[k*CfgWidth +: CfgWidth];
            end
        end
    end

    // Switch sequencer; outputs are registered alongside the state transitions.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= ST_INIT;
            cnt           <= '0;
            active_idx    <= DEFAULT_IDX;
            target_idx    <= DEFAULT_IDX;
            abort         <= 1'b0;
            isolate_req_o <= 1'b0;
            cfg_valid_o   <= 1'b0;
            req_ready_o   <= 1'b0;
            done_o        <= 1'b0;
            err_o         <= 1'b0;
        end else begin
            done_o <= 1'b0;
            err_o  <= 1'b0;
            case (state)
                ST_INIT: begin
                    if (cnt == SETTLE_LAST) begin
                        state       <= ST_IDLE;
                        cnt         <= '0;
                        req_ready_o <= 1'b1;
                        cfg_valid_o <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_IDLE: begin
                    // req_ready_o is high throughout IDLE, so valid alone is a handshake.
                    if (req_valid_i) begin
                        if (idx_oob) begin
                            err_o <= 1'b1;
                        end else if (req_idx_i == active_idx) begin
                            done_o <= 1'b1;
                        end else begin
                            target_idx    <= req_idx_i;
                            state         <= ST_DRAIN;
                            cnt           <= '0;
                            req_ready_o   <= 1'b0;
                            cfg_valid_o   <= 1'b0;
                            isolate_req_o <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    // A clean ack wins over a timeout landing in the same cycle.
                    if (isolate_ack_i && !busy_i) begin
                        state <= ST_APPLY;
                        cnt   <= '0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        abort         <= 1'b1;
                        state         <= ST_RELEASE;
                        cnt           <= '0;
                        isolate_req_o <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_APPLY: begin
                    active_idx <= target_idx;
                    cnt        <= '0;
                    if (SettleCycles == 0) begin
                        state         <= ST_RELEASE;
                        isolate_req_o <= 1'b0;
                    end else begin
                        state <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        state         <= ST_RELEASE;
                        cnt           <= '0;
                        isolate_req_o <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_RELEASE: begin
                    if (!isolate_ack_i) begin
                        state       <= ST_IDLE;
                        req_ready_o <= 1'b1;
                        cfg_valid_o <= 1'b1;
                        done_o      <= !abort;
                        err_o       <= abort;
                        abort       <= 1'b0;
                    end
                end
                default: begin
                    state         <= ST_INIT;
                    cnt           <= '0;
                    isolate_req_o <= 1'b0;
                    cfg_valid_o   <= 1'b0;
                    req_ready_o   <= 1'b0;
                end
            endcase
        end
    end

endmodule
